// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared op/state encodings and access-shape helpers for the memory stage.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_store(input op_e op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_half(input op_e op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_byte(input op_e op);
        return op inside {OP_LB, OP_LBU, OP_SB};
    endfunction

    function automatic logic misaligned(input op_e op, input logic [1:0] off);
        return is_byte(op) ? 1'b0 : is_half(op) ? off[0] : |off;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: byte enables, store lane replication and load extraction/extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        be = is_byte(op) ? 4'b0001 << off : is_half(op) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_rep = is_byte(op) ? {4{wdata[7:0]}} : is_half(op) ? {2{wdata[15:0]}} : wdata;
        load_data = op == OP_LB  ? {{24{b[7]}}, b} :
                    op == OP_LBU ? {24'b0, b} :
                    op == OP_LH  ? {{16{h[15]}}, h} :
                    op == OP_LHU ? {16'b0, h} :
                    op == OP_LW  ? rdata : 32'b0;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store initiator with req/ack handshake, alignment checks and bus timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    state_e      state;
    logic [7:0]  cnt;
    op_e         op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    op_e         op_in;

    assign op_in = op_e'(op_type);

    mem_lane_align u_align (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .load_data (load_data)
    );

    assign stall     = (state == S_IDLE && op_valid) || state == S_REQ;
    assign mem_we    = mem_req && is_store(op_q);
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_be    = mem_req ? be : 4'b0;
    assign mem_wdata = mem_req ? wdata_rep : 32'b0;

    // A timeout drops mem_req on the edge the counter reaches MAX_WAIT; the
    // following REQ cycle (request already withdrawn) reports the bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= OP_LW;
            addr_q   <= '0;
            wdata_q  <= '0;
            done     <= 1'b0;
            rdata    <= '0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            exc_bus  <= 1'b0;
            mem_req  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (op_valid) begin
                    op_q    <= op_in;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    cnt     <= '0;
                    if (misaligned(op_in, addr[1:0])) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        exc_adel <= !is_store(op_in);
                        exc_ades <= is_store(op_in);
                    end else begin
                        state   <= S_REQ;
                        mem_req <= 1'b1;
                    end
                end
                S_REQ: if (mem_req && mem_ack) begin
                    state   <= S_DONE;
                    done    <= 1'b1;
                    mem_req <= 1'b0;
                    rdata   <= load_data;
                end else if (!mem_req) begin
                    state   <= S_DONE;
                    done    <= 1'b1;
                    exc_bus <= 1'b1;
                end else begin
                    cnt     <= cnt + 8'd1;
                    mem_req <= cnt != LAST;
                end
                default: begin
                    state    <= S_IDLE;
                    rdata    <= '0;
                    exc_adel <= 1'b0;
                    exc_ades <= 1'b0;
                    exc_bus  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit with default and short (3-cycle) timeout instances.
module tb_mem_access_unit;

    typedef struct {
        int          lat;
        int          reqs;
        int          stalls;
        logic [31:0] rdat;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mbe;
        logic        mwe;
        logic [2:0]  exc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  op_type = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        op_valid = 1'b0, mem_ack = 1'b0;
    logic        op_valid_w = 1'b0, mem_ack_w = 1'b0;

    logic        stall, done, exc_adel, exc_ades, exc_bus, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        stall_w, done_w, exc_adel_w, exc_ades_w, exc_bus_w, mem_req_w, mem_we_w;
    logic [31:0] rdata_w, mem_addr_w, mem_wdata_w;
    logic [3:0]  mem_be_w;

    int tests = 0;
    int fails = 0;
    res_t r;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.MAX_WAIT(3)) dut_w (
        .clk(clk), .rst(rst), .op_valid(op_valid_w), .op_type(op_type), .addr(addr), .wdata(wdata),
        .stall(stall_w), .done(done_w), .rdata(rdata_w), .exc_adel(exc_adel_w), .exc_ades(exc_ades_w),
        .exc_bus(exc_bus_w), .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_be(mem_be_w),
        .mem_wdata(mem_wdata_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts an access at a negedge and follows it until done, raising ack on the ack_at-th request cycle.
    task automatic run(input bit w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at, output res_t o);
        o = '{default: 0};
        op_type = op;
        addr = a;
        wdata = wd;
        mem_rdata = rd;
        if (w) op_valid_w = 1'b1; else op_valid = 1'b1;
        #1;
        if (w ? stall_w : stall) o.stalls++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            o.lat = c;
            if (w ? done_w : done) break;
            if (w ? stall_w : stall) o.stalls++;
            if (w ? mem_req_w : mem_req) begin
                o.reqs++;
                if (o.reqs == 1) begin
                    o.maddr = w ? mem_addr_w : mem_addr;
                    o.mwd   = w ? mem_wdata_w : mem_wdata;
                    o.mbe   = w ? mem_be_w : mem_be;
                    o.mwe   = w ? mem_we_w : mem_we;
                end
            end
            if (w) mem_ack_w = mem_req_w && o.reqs == ack_at;
            else   mem_ack   = mem_req && o.reqs == ack_at;
        end
        o.rdat = w ? rdata_w : rdata;
        o.exc  = w ? {exc_adel_w, exc_ades_w, exc_bus_w} : {exc_adel, exc_ades, exc_bus};
        op_valid = 1'b0;
        op_valid_w = 1'b0;
        mem_ack = 1'b0;
        mem_ack_w = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(0, 3'd7, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, r);
        chk("sb_lat", r.lat, 2);
        chk("sb_be", {28'b0, r.mbe}, 32'h8);
        chk("sb_wdata", r.mwd, 32'hA5A5_A5A5);
        chk("sb_addr", r.maddr, 32'h0000_1000);
        chk("sb_we", {31'b0, r.mwe}, 32'd1);
        chk("sb_exc", {29'b0, r.exc}, 32'd0);
        chk("sb_rdata", r.rdat, 32'd0);

        run(0, 3'd1, 32'h0000_0002, 32'h0, 32'h8001_1234, 1, r);
        chk("lh_rdata", r.rdat, 32'hFFFF_8001);
        chk("lh_be", {28'b0, r.mbe}, 32'hC);
        chk("lh_we", {31'b0, r.mwe}, 32'd0);
        run(0, 3'd2, 32'h0000_0002, 32'h0, 32'h8001_1234, 1, r);
        chk("lhu_rdata", r.rdat, 32'h0000_8001);
        run(0, 3'd3, 32'h0000_0001, 32'h0, 32'h8001_1234, 1, r);
        chk("lb_rdata", r.rdat, 32'h0000_0012);
        chk("lb_be", {28'b0, r.mbe}, 32'h2);
        run(0, 3'd3, 32'h0000_0003, 32'h0, 32'h8001_1234, 1, r);
        chk("lb_neg_rdata", r.rdat, 32'hFFFF_FF80);
        run(0, 3'd4, 32'h0000_0003, 32'h0, 32'h8001_1234, 1, r);
        chk("lbu_rdata", r.rdat, 32'h0000_0080);
        run(0, 3'd6, 32'h0000_0040, 32'h1234_BEEF, 32'h0, 1, r);
        chk("sh_be", {28'b0, r.mbe}, 32'h3);
        chk("sh_wdata", r.mwd, 32'hBEEF_BEEF);

        run(0, 3'd0, 32'h0000_0006, 32'h0, 32'h0, 1, r);
        chk("lw_mis_lat", r.lat, 1);
        chk("lw_mis_reqs", r.reqs, 0);
        chk("lw_mis_exc", {29'b0, r.exc}, 32'b100);
        chk("lw_mis_rdata", r.rdat, 32'd0);
        run(0, 3'd6, 32'h0000_0005, 32'h0, 32'h0, 1, r);
        chk("sh_mis_lat", r.lat, 1);
        chk("sh_mis_reqs", r.reqs, 0);
        chk("sh_mis_exc", {29'b0, r.exc}, 32'b010);

        run(1, 3'd5, 32'h0000_0020, 32'h1111_2222, 32'h0, 0, r);
        chk("to_reqs", r.reqs, 3);
        chk("to_lat", r.lat, 5);
        chk("to_exc", {29'b0, r.exc}, 32'b001);
        chk("to_rdata", r.rdat, 32'd0);
        chk("to_we", {31'b0, r.mwe}, 32'd1);
        run(1, 3'd0, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 3, r);
        chk("ack3_lat", r.lat, 4);
        chk("ack3_exc", {29'b0, r.exc}, 32'd0);
        chk("ack3_rdata", r.rdat, 32'h1357_9BDF);

        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_done", {31'b0, done}, 32'd0);
        chk("idle_ack_req", {31'b0, mem_req}, 32'd0);
        run(0, 3'd0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 5, r);
        chk("lw5_lat", r.lat, 6);
        chk("lw5_stalls", r.stalls, 6);
        chk("lw5_rdata", r.rdat, 32'hDEAD_BEEF);
        chk("lw5_exc", {29'b0, r.exc}, 32'd0);

        op_type = 3'd0;
        addr = 32'h0000_0008;
        op_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_req_before", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_state", {30'b0, dut.state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_done", {31'b0, done}, 32'd0);
        run(0, 3'd0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1, r);
        chk("post_rst_lat", r.lat, 2);
        chk("post_rst_rdata", r.rdat, 32'hCAFE_F00D);
        chk("post_rst_exc", {29'b0, r.exc}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage initiator that drives the data-memory port for all MIPS load/store instructions (lw, lh, lhu, lb, lbu, sw, sh, sb). It sits between the M pipeline stage and a variable-latency data memory. It generates byte enables and lane-replicated store data, and runs a req/ack handshake with the memory. It sign- or zero-extends load data, flags misaligned accesses and bus timeouts, and stalls the pipeline until the access completes.

## Interface
- MAX_WAIT, default 15: REQ cycles without mem_ack before a bus error is declared (1..255).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  M stage holds a load/store; held stable until `done`.
- op_type  in  3  access kind; encoding is defined in the shared package.
- addr  in  32  effective byte address.
- wdata  in  32  store source (rt value).
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while `done`=1.
- exc_adel  out  1  misaligned load; valid with `done`.
- exc_ades  out  1  misaligned store; valid with `done`.
- exc_bus  out  1  timeout; valid with `done`.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted request; read data is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - With op_valid=1, latch op_type, addr and wdata, and clear the wait counter.
  - Aligned access: go to REQ.
  - Misaligned access: go to DONE with the exception flag set; no memory request is issued.
  - Alignment rule: word accesses need addr[1:0]=0; half-word accesses need addr[0]=0; byte accesses are always aligned.
- **REQ**
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata come from the latched values and stay stable until ack.
  - On mem_ack=1: capture the extended load data (stores: rdata=0) and go to DONE.
  - Without ack: increment the wait counter. When the counter reaches MAX_WAIT, drop the request, set exc_bus, set rdata=0 and go to DONE.
- **DONE**
  - done=1 for exactly one cycle; stall=0; op_valid is ignored.
  - Next state is IDLE.
- **Byte enables** (off = addr[1:0])
  - Byte: 4'b0001<<off.
  - Half-word: off=0 → 4'b0011; off=2 → 4'b1100.
  - Word: 4'b1111.
- **Store data:** sb → {4{wdata[7:0]}}; sh → {2{wdata[15:0]}}; sw → wdata.
- **Load extraction:** select the byte or half at mem_rdata[8*off +: 8] or [8*off +: 16].
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes the word through.
- mem_ack outside REQ is ignored.
- stall = (IDLE & op_valid) | REQ.

## Timing
- Reset values: all outputs 0, state IDLE, wait counter 0.
- rst in REQ drops mem_req in the same clock edge. Any in-flight access is abandoned and no `done` is produced.
- Latency from op_valid rising in IDLE:
  - ack in the first REQ cycle: `done` at cycle +2.
  - ack on the k-th REQ cycle: `done` at cycle +1+k.
  - misaligned access: `done` at cycle +1.
  - timeout: `done` at cycle +1+MAX_WAIT+1.
- The pipeline advances at the end of the DONE cycle. The next op_valid is sampled in the following IDLE cycle, so back-to-back accesses have one idle-free gap.
- If ack arrives in the same cycle the counter hits MAX_WAIT, ack wins: normal completion, no exc_bus.
- Exactly one of {normal, exc_adel, exc_ades, exc_bus} completes each access.

## Structure
- Shared package holds:
  - op_type encodings: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - FSM state encodings.
  - Helpers is_store / is_half / is_byte.
- One sub-module, mem_lane_align: purely combinational. Takes type and offset, produces be and store replication; takes type, offset and rdata, produces extended load data.
- The FSM, the wait counter and the latches stay in mem_access_unit.

## Test plan
- sb, addr=0x1003, wdata=0x000000A5, ack on the first REQ cycle → mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1, `done` at +2, no exception.
- lh, addr=0x0002, mem_rdata=0x8001_1234 → rdata=0xFFFF8001. Repeated as lhu → 0x00008001. Repeated as lb with addr=0x0001 → 0x00000012.
- lw, addr=0x0006 → no mem_req ever; `done` with exc_adel=1 at +1. sh with addr=0x0005 → exc_ades=1.
- sw with MAX_WAIT=3 and ack held low → mem_req high for 3 cycles, then `done` with exc_bus=1 and rdata=0. Repeated with ack on the 3rd cycle → normal completion, exc_bus=0.
- lw with ack delayed 5 cycles, and mem_ack=1 pulsed while IDLE beforehand → the IDLE ack is ignored; stall high for 6 cycles; `done` at +6 with rdata=mem_rdata.
- rst asserted on the 2nd REQ cycle → next cycle mem_req=0, stall=0, done=0, state IDLE. A fresh lw then completes normally.
